// File: rtl/slider_pkg.sv
// Shared constants and types for the sliding-tile puzzle core.
// Direction codes describe how the blank moves.
package slider_pkg;

  localparam logic [1:0] DIR_UP = 2'd0;
  localparam logic [1:0] DIR_DN = 2'd1;
  localparam logic [1:0] DIR_LT = 2'd2;
  localparam logic [1:0] DIR_RT = 2'd3;

  typedef enum logic {
    PLAY     = 1'b0,
    SCRAMBLE = 1'b1
  } state_e;

  // taps at bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'h0001;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/slider_puzzle_if.sv
// Player/scramble request and board status bundle.
// The bench drives through master; the core sits on slave.
interface slider_puzzle_if #(
  parameter int ROWS = 2,
  parameter int COLS = 4,
  parameter int MCW  = 16
);
  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(N);

  logic            move_req;
  logic [1:0]      move_dir;
  logic            scr_start;
  logic [15:0]     scr_seed;
  logic [MCW-1:0]  scr_len;
  logic [N*CW-1:0] board;
  logic [CW-1:0]   blank_pos;
  logic            move_ok;
  logic            move_err;
  logic [MCW-1:0]  move_count;
  logic            solved;
  logic            busy;
  logic            parity_ok;

  modport master (
    output move_req, move_dir,
    output scr_start, scr_seed, scr_len,
    input  board, blank_pos,
    input  move_ok, move_err, move_count,
    input  solved, busy, parity_ok
  );

  modport slave (
    input  move_req, move_dir,
    input  scr_start, scr_seed, scr_len,
    output board, blank_pos,
    output move_ok, move_err, move_count,
    output solved, busy, parity_ok
  );

endinterface

// File: rtl/slider_lfsr16.sv
// 16-bit Fibonacci LFSR supplying scramble directions.
// A zero seed is replaced so the register never locks up.
module slider_lfsr16
  import slider_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load_i,
  input  logic [15:0] seed_i,
  input  logic        adv_i,
  output logic [1:0]  dir_o
);

  logic [15:0] state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LFSR_SEED;
    end else if (load_i) begin
      state_q <= (seed_i == 16'h0) ? LFSR_SEED : seed_i;
    end else if (adv_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign dir_o = state_q[1:0];

endmodule

// File: rtl/slider_puzzle.sv
// ROWS x COLS sliding-tile board with player moves,
// a self-driven scrambler, move counter and invariants.
module slider_puzzle
  import slider_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 4,
  parameter int CW   = $clog2(ROWS * COLS),
  parameter int MCW  = 16
) (
  input  logic           clock,
  input  logic           reset,
  slider_puzzle_if.slave bus
);

  localparam int N = ROWS * COLS;

  state_e               state_q;
  logic [N-1:0][CW-1:0] board_q;
  logic [CW-1:0]        blank_q;
  logic [MCW-1:0]       count_q;
  logic [MCW-1:0]       remain_q;
  logic                 ok_q;
  logic                 err_q;
  logic                 par_q;

  logic [1:0]    lfsr_dir;
  logic [1:0]    dir_sel;
  logic          legal;
  logic [CW-1:0] tgt;
  logic          do_move;
  logic          solved_c;

  // {legal, target} for moving the blank at b in direction d
  function automatic logic [CW:0] step_fn(
    input logic [CW-1:0] b,
    input logic [1:0]    d
  );
    int   r;
    int   c;
    int   t;
    logic ok;
    r  = int'(b) / COLS;
    c  = int'(b) % COLS;
    ok = 1'b0;
    t  = int'(b);
    unique case (d)
      DIR_UP: begin ok = (r > 0);        t = t - COLS; end
      DIR_DN: begin ok = (r < ROWS - 1); t = t + COLS; end
      DIR_LT: begin ok = (c > 0);        t = t - 1;    end
      DIR_RT: begin ok = (c < COLS - 1); t = t + 1;    end
    endcase
    return {ok, CW'(t)};
  endfunction

  function automatic logic rc_par(
    input logic [CW-1:0] b
  );
    int v;
    v = int'(b) / COLS + int'(b) % COLS;
    return v[0];
  endfunction

  slider_lfsr16 u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .load_i (state_q == PLAY && bus.scr_start),
    .seed_i (bus.scr_seed),
    .adv_i  (state_q == SCRAMBLE),
    .dir_o  (lfsr_dir)
  );

  always_comb begin
    dir_sel = (state_q == SCRAMBLE) ? lfsr_dir
                                    : bus.move_dir;
    {legal, tgt} = step_fn(blank_q, dir_sel);
    do_move = 1'b0;
    if (state_q == PLAY)
      do_move = legal && bus.move_req
                && !bus.scr_start;
    else
      do_move = legal && (remain_q != '0);
  end

  always_comb begin
    solved_c = 1'b1;
    for (int i = 0; i < N; i++)
      if (board_q[i] != CW'(i)) solved_c = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++)
        board_q[i] <= CW'(i);
      blank_q  <= '0;
      state_q  <= PLAY;
      count_q  <= '0;
      remain_q <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      ok_q  <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        PLAY: begin
          if (bus.scr_start) begin
            remain_q <= bus.scr_len;
            state_q  <= SCRAMBLE;
          end else if (bus.move_req) begin
            ok_q  <= legal;
            err_q <= !legal;
            if (legal && !(&count_q))
              count_q <= count_q + MCW'(1);
          end
        end
        SCRAMBLE: begin
          if (remain_q == '0) begin
            state_q <= PLAY;
            count_q <= '0;
          end else if (legal) begin
            remain_q <= remain_q - MCW'(1);
          end
        end
      endcase
      if (do_move) begin
        board_q[blank_q] <= board_q[tgt];
        board_q[tgt]     <= '0;
        blank_q          <= tgt;
        par_q            <= ~par_q;
      end
    end
  end

  assign bus.board      = board_q;
  assign bus.blank_pos  = blank_q;
  assign bus.move_ok    = ok_q;
  assign bus.move_err   = err_q;
  assign bus.move_count = count_q;
  assign bus.busy       = (state_q == SCRAMBLE);
  assign bus.solved     = solved_c;
  assign bus.parity_ok  = (par_q == rc_par(blank_q));

endmodule

// File: tb/tb_slider_puzzle.sv
// Directed bench: 2x4 core for moves/scramble/reset,
// 3x3 core with 4-bit counter for random walk and saturation.
module tb_slider_puzzle;

  localparam logic [1:0] UP = 2'd0;
  localparam logic [1:0] DN = 2'd1;
  localparam logic [1:0] LT = 2'd2;
  localparam logic [1:0] RT = 2'd3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  slider_puzzle_if #(.ROWS(2), .COLS(4), .MCW(16)) a ();
  slider_puzzle_if #(.ROWS(3), .COLS(3), .MCW(4))  b ();

  slider_puzzle #(.ROWS(2), .COLS(4), .MCW(16)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (a)
  );

  slider_puzzle #(.ROWS(3), .COLS(3), .MCW(4)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (b)
  );

  int errs   = 0;
  int checks = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] id8();
    logic [23:0] v;
    for (int i = 0; i < 8; i++) v[i*3 +: 3] = 3'(i);
    return v;
  endfunction

  function automatic logic [35:0] id9();
    logic [35:0] v;
    for (int i = 0; i < 9; i++) v[i*4 +: 4] = 4'(i);
    return v;
  endfunction

  function automatic logic [23:0] sw(
    input logic [23:0] v,
    input int          i,
    input int          j
  );
    logic [23:0] r;
    r = v;
    r[i*3 +: 3] = v[j*3 +: 3];
    r[j*3 +: 3] = v[i*3 +: 3];
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mv(input logic [1:0] d);
    a.move_req = 1'b1;
    a.move_dir = d;
    tick();
    a.move_req = 1'b0;
  endtask

  logic [23:0] pre;
  logic [7:0]  seen;
  logic [2:0]  bl_prev;
  int          moves;
  int          cyc;
  int          bl;
  int          nok;
  int          r;
  int          c;
  logic        lg;
  logic        req;
  logic [1:0]  d;

  initial begin
    reset = 1'b1;
    a.move_req = 0; a.move_dir = 0; a.scr_start = 0;
    a.scr_seed = 0; a.scr_len = 0;
    b.move_req = 0; b.move_dir = 0; b.scr_start = 0;
    b.scr_seed = 0; b.scr_len = 0;
    #12;
    check("rst_board", a.board, id8());
    check("rst_blank", a.blank_pos, 0);
    check("rst_solved", a.solved, 1);
    check("rst_count", a.move_count, 0);
    check("rst_busy", a.busy, 0);
    check("rst_par", a.parity_ok, 1);
    check("rst_pulse", {a.move_ok, a.move_err}, 0);
    check("rst_board9", b.board, id9());
    @(negedge clock);
    reset = 1'b0;

    mv(RT);
    check("rt_board", a.board, sw(id8(), 0, 1));
    check("rt_blank", a.blank_pos, 1);
    check("rt_solved", a.solved, 0);
    check("rt_count", a.move_count, 1);
    check("rt_ok", {a.move_ok, a.move_err}, 2'b10);
    check("rt_par", a.parity_ok, 1);
    mv(LT);
    check("lt_board", a.board, id8());
    check("lt_solved", a.solved, 1);
    check("lt_count", a.move_count, 2);
    tick();
    check("idle_pulse", {a.move_ok, a.move_err}, 0);
    mv(UP);
    check("up_err", {a.move_ok, a.move_err}, 2'b01);
    check("up_board", a.board, id8());
    check("up_count", a.move_count, 2);
    mv(DN);
    check("dn_board", a.board, sw(id8(), 0, 4));
    check("dn_blank", a.blank_pos, 4);
    check("dn_count", a.move_count, 3);
    check("dn_par", a.parity_ok, 1);
    mv(DN);
    check("dn2_err", {a.move_ok, a.move_err}, 2'b01);
    check("dn2_blank", a.blank_pos, 4);
    check("dn2_count", a.move_count, 3);
    mv(LT);
    check("lt4_err", {a.move_ok, a.move_err}, 2'b01);

    // scramble with a simultaneous move request
    a.scr_start = 1; a.scr_seed = 16'hACE1;
    a.scr_len = 16'd20;
    a.move_req = 1; a.move_dir = RT;
    tick();
    a.scr_start = 0;
    check("scr_busy", a.busy, 1);
    check("scr_drop", {a.move_ok, a.move_err}, 0);
    check("scr_board0", a.board, sw(id8(), 0, 4));
    check("scr_count0", a.move_count, 3);
    moves = 0;
    cyc = 0;
    while (a.busy && cyc < 1000) begin
      bl_prev = a.blank_pos;
      a.move_dir = 2'($urandom_range(0, 3));
      tick();
      cyc++;
      if (a.blank_pos != bl_prev) moves++;
      check("scr_par", a.parity_ok, 1);
      check("scr_pulse", {a.move_ok, a.move_err}, 0);
    end
    a.move_req = 0;
    check("scr_done", a.busy, 0);
    check("scr_moves", moves, 20);
    check("scr_count", a.move_count, 0);
    seen = '0;
    for (int i = 0; i < 8; i++)
      seen[a.board[i*3 +: 3]] = 1'b1;
    check("scr_perm", seen, 8'hFF);
    check("scr_blank0", a.board[a.blank_pos*3 +: 3], 0);

    mv(LT);
    mv(RT);
    pre = a.board;
    check("pre_count", a.move_count != 0, 1);
    a.scr_start = 1; a.scr_seed = 16'h0;
    a.scr_len = 16'd0;
    tick();
    a.scr_start = 0;
    check("z_busy1", a.busy, 1);
    tick();
    check("z_busy0", a.busy, 0);
    check("z_board", a.board, pre);
    check("z_count", a.move_count, 0);

    a.scr_start = 1; a.scr_seed = 16'h1234;
    a.scr_len = 16'd50;
    tick();
    a.scr_start = 0;
    tick();
    tick();
    check("mid_busy", a.busy, 1);
    reset = 1'b1;
    #1;
    check("mid_board", a.board, id8());
    check("mid_blank", a.blank_pos, 0);
    check("mid_busy0", a.busy, 0);
    @(negedge clock);
    reset = 1'b0;

    // 3x3 random walk against a blank-position model
    bl  = 0;
    nok = 0;
    for (int k = 0; k < 200; k++) begin
      req = ($urandom_range(0, 3) != 0);
      d   = 2'($urandom_range(0, 3));
      r   = bl / 3;
      c   = bl % 3;
      case (d)
        UP: lg = (r > 0);
        DN: lg = (r < 2);
        LT: lg = (c > 0);
        default: lg = (c < 2);
      endcase
      b.move_req = req;
      b.move_dir = d;
      tick();
      if (req && lg) begin
        nok++;
        case (d)
          UP: bl = bl - 3;
          DN: bl = bl + 3;
          LT: bl = bl - 1;
          default: bl = bl + 1;
        endcase
      end
      check("w_ok", b.move_ok, req && lg);
      check("w_err", b.move_err, req && !lg);
      check("w_blank", b.blank_pos, bl);
      check("w_par", b.parity_ok, 1);
      if (k == 3)
        check("w_cnt_early", b.move_count, nok);
    end
    b.move_req = 0;
    check("w_sat", b.move_count, (nok > 15) ? 15 : nok);
    check("w_blank0", b.board[b.blank_pos*4 +: 4], 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule

// File: doc/slider_puzzle.md
# slider_puzzle

Parametrised ROWS×COLS sliding-tile puzzle engine: successor of the fixed 2×4 model, with a tracked blank position, direction-based moves, a guaranteed-solvable built-in scrambler, move counting and a solved flag. It is the board core for puzzle-based model-checking and simulation experiments. Legal moves keep the board a permutation by construction, so no initial-state filtering is needed.

## Interface
- ROWS, 2, board rows (≥2)
- COLS, 4, board columns (≥2)
- CW, $clog2(ROWS*COLS), cell index/value width (derived; do not override)
- MCW, 16, move counter width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- move_req  in  1  request one player move this cycle
- move_dir  in  2  blank motion: 0 up, 1 down, 2 left, 3 right
- scr_start  in  1  begin scramble (PLAY state only)
- scr_seed  in  16  LFSR seed, sampled with scr_start
- scr_len  in  MCW  number of legal scramble moves
- board  out  ROWS*COLS*CW  cell i at bits [i*CW +: CW]; value 0 is blank
- blank_pos  out  CW  index of blank cell
- move_ok  out  1  one-cycle pulse: legal player move applied
- move_err  out  1  one-cycle pulse: player move rejected
- move_count  out  MCW  legal player moves since last reset/scramble
- solved  out  1  board equals identity
- busy  out  1  scramble in progress
- parity_ok  out  1  invariant check, must always be 1

## Operation
- Cells indexed row-major, i = r*COLS + c; solved ⇔ cell i holds i for all i (blank at 0).
- Reset (async): board identity, blank_pos 0, FSM PLAY, move_count 0, move_ok/move_err 0, busy 0, solved 1, parity register 0, LFSR 16'h0001.
- Move legality by blank (r,c): up needs r>0, down r<ROWS-1, left c>0, right c<COLS-1. Target t = blank ±COLS / ±1.
- Legal move: cell[blank] ← cell[t], cell[t] ← 0, blank_pos ← t, parity register toggles.
- PLAY: move_req legal → apply, move_ok=1, move_count+1 (saturates at all-ones). Illegal → board unchanged, move_err=1, count unchanged.
- scr_start in PLAY (takes priority over simultaneous move_req, which is dropped without pulse): LFSR ← scr_seed (0 replaced by 16'h0001), remaining ← scr_len, go SCRAMBLE. scr_len=0 → one SCRAMBLE cycle then PLAY.
- SCRAMBLE: each cycle if remaining==0 → PLAY, move_count ← 0. Else dir = LFSR[1:0]; legal → apply, remaining−1; illegal → skip. LFSR advances every cycle. move_req ignored (no pulse); scr_start ignored.
- LFSR: Fibonacci, shift left, feedback = l[15]^l[13]^l[12]^l[10] into bit 0.
- parity_ok = parity register == ((r+c) of blank_pos) mod 2.
- Reset mid-scramble aborts to reset state.

## Timing
- Inputs sampled at rising edge N; board, blank_pos, move_count, move_ok/move_err visible after edge N (single-cycle latency); pulses last one cycle.
- solved, parity_ok combinational from registered board/blank_pos.
- busy=1 from edge after scr_start through last SCRAMBLE cycle; a scramble of k legal moves with s skips takes k+s+1 cycles.
- Back-to-back moves every cycle supported.

## Structure
- Package slider_pkg: direction encoding constants, FSM enum {PLAY, SCRAMBLE}, LFSR tap constant, default seed.
- Sub-module slider_lfsr16 (load, seed, advance, 16-bit state).
- Top holds board array, blank_pos, FSM, counters; shared legality/target function used by player and scramble paths.

## Test plan
- Reset with ROWS=2, COLS=4 → board 0..7 identity, blank_pos 0, solved 1, move_count 0, busy 0.
- Move right then left from reset → after first: cell0=1, cell1=0, blank_pos 1, solved 0, count 1; after second: solved 1, count 2.
- Move up at blank 0 → move_err pulse, board/count unchanged; down then move down at blank 4 → second errs.
- scr_start seed 16'hACE1, scr_len 20 → busy until 20 legal moves done, move_count 0, board permutation, parity_ok 1 every cycle; move_req during busy ignored.
- scr_len 0 and seed 0 → one busy cycle, board unchanged; reset asserted mid-scramble → immediate identity board.
- ROWS=3, COLS=3: 200 random move_req cycles → parity_ok always 1, count = number of move_ok pulses, MCW=4 saturates at 15.
